xeng_bl_sched: RTL and testbench
================================

# xeng_bl_sched

Baseline-pass scheduler for the X-engine. It turns upstream "window ready" requests into back-to-back baseline passes, and drives the sync/enable pins of the baseline order generator. It tags each pass with accumulate-control flags (first/last spectrum of an integration) for the downstream vector accumulator. It sits between the antenna-window buffer and the order generator/correlator datapath.

## Interface
- `N_ANTS`, 16, antenna count (power of 2, ≥4); `BL_PER_WIN = N_ANTS*(N_ANTS/2+1)` is a localparam giving cycles per pass (144 at default).
- `ACC_BITS`, 32, width of the accumulation-length register and spectrum counter.
- `clk` input 1: sole clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `sync` input 1: integration start/abort pulse; latches `acc_len`.
- `acc_len` input ACC_BITS: spectra per integration; 0 is treated as 1.
- `win_req` input 1: one-cycle pulse, one antenna window loaded and ready to correlate.
- `bl_sync` output 1: one-cycle reset pulse to the order generator before every pass.
- `bl_en` output 1: order-generator enable, high for exactly BL_PER_WIN consecutive cycles per pass.
- `acc_first` output 1: valid while `bl_en`=1; pass is spectrum 0 of the integration (overwrite, not add).
- `acc_last` output 1: valid while `bl_en`=1; pass is the final spectrum (accumulator dumps).
- `win_done` output 1: one-cycle pulse the cycle after the last `bl_en` of a pass.
- `int_done` output 1: one-cycle pulse coincident with `win_done` of the last pass.
- `overflow` output 1: sticky; a `win_req` was dropped.

## Operation
- States: IDLE, WAIT, SYNC, RUN.
  - IDLE: after `rst`; `win_req` is ignored and never raises `overflow`.
  - `sync` in any state: go to WAIT, latch `acc_len` (0→1), spec_cnt←0, pending←0, `overflow`←0. The pass in flight is aborted and `bl_en` drops the next cycle.
  - WAIT + `win_req`: go to SYNC. If `sync` and `win_req` occur in the same cycle, `win_req` is the first window of the new integration and the next state is SYNC.
  - SYNC: one cycle, `bl_sync`=1, bl_cnt←0; then go to RUN.
  - RUN: `bl_en`=1 while bl_cnt counts 0..BL_PER_WIN-1.
    - At bl_cnt=BL_PER_WIN-1: spec_cnt increments. If it reaches acc_len it wraps to 0 and `int_done` pulses. The next integration starts automatically with no new `sync`.
    - The next state is SYNC if a window is pending or `win_req` is high that cycle. Otherwise the next state is WAIT.
- `acc_first` = (spec_cnt==0); `acc_last` = (spec_cnt==acc_len_latched-1). With acc_len=1 both are high on every pass.
- Pending slot (one deep):
  - `win_req` during SYNC or RUN (excluding the final RUN cycle) with pending=0 sets pending.
  - `win_req` with pending=1 is dropped and sets `overflow`.
  - Pending clears when SYNC is entered from RUN.
- Counters wrap only as stated; bl_cnt width is ceil(log2(BL_PER_WIN)).

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, pending 0.
- `win_req` accepted in WAIT at cycle t: `bl_sync` at t+1, `bl_en` at t+2..t+1+BL_PER_WIN, `win_done` at t+2+BL_PER_WIN.
- Back-to-back pass period is BL_PER_WIN+1 cycles (one SYNC bubble). `win_done` is coincident with the next pass's `bl_sync`.
- `acc_first`/`acc_last` are registered and stable across all BL_PER_WIN cycles of a pass.
- All outputs are registered; there are no combinational input→output paths.

## Configuration
- `XENG_BL_SCHED_STATUS_EN` defined:
  - Adds output `int_cnt` [ACC_BITS-1:0], the count of completed integrations since the last `sync`/`rst`; it wraps.
  - Adds output `drop_cnt` [15:0], the count of dropped `win_req`; it saturates at 0xFFFF; cleared by `sync`/`rst`.
- Undefined: neither port exists and no counters are synthesized. All other behaviour is identical.

## Test plan
- N_ANTS=4 (BL_PER_WIN=12), acc_len=3, `sync` then `win_req` at t=10 → `bl_sync` at 11; `bl_en` 12..23 with `acc_first`=1, `acc_last`=0; `win_done` at 24.
- Three windows requested early (each during the prior pass) → passes are contiguous with one-cycle bubbles. Flags are (1,0), (0,0), (0,1). `int_done` fires with the third `win_done`. A 4th window has `acc_first`=1 again.
- acc_len=0 → behaves as 1: every pass has `acc_first`=`acc_last`=1 and `int_done` fires on every `win_done`.
- Two `win_req` during one RUN pass → the first sets pending and the second sets `overflow`=1. The next pass still starts; `drop_cnt`=1 when `XENG_BL_SCHED_STATUS_EN` is defined.
- `sync` at bl_cnt=5 of a pass → `bl_en` low the next cycle, no `win_done`, `overflow` cleared. The next `win_req` gives `acc_first`=1.
- `win_req` before any `sync` → ignored, no `bl_sync`, `overflow`=0; `rst` mid-RUN → all outputs 0 the next cycle.

Source files
------------

// File: rtl/xeng_bl_sched.sv
// Baseline-pass scheduler: turns window-ready requests into back-to-back order-generator passes
// and tags each pass with accumulate first/last flags. Optional status counters: XENG_BL_SCHED_STATUS_EN.
module xeng_bl_sched #(
    parameter int N_ANTS   = 16,
    parameter int ACC_BITS = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sync,
    input  logic [ACC_BITS-1:0] acc_len,
    input  logic                win_req,
    output logic                bl_sync,
    output logic                bl_en,
    output logic                acc_first,
    output logic                acc_last,
    output logic                win_done,
    output logic                int_done,
`ifdef XENG_BL_SCHED_STATUS_EN
    output logic [ACC_BITS-1:0] int_cnt,
    output logic [15:0]         drop_cnt,
`endif
    output logic                overflow
);
    localparam int BL_PER_WIN = N_ANTS * (N_ANTS / 2 + 1);
    localparam int BL_W       = $clog2(BL_PER_WIN);
    localparam logic [BL_W-1:0] BL_LAST = BL_W'(BL_PER_WIN - 1);

    typedef enum logic [1:0] {IDLE, WAIT, SYNC, RUN} state_t;

    state_t              state, state_nx;
    logic [BL_W-1:0]     bl_cnt, bl_cnt_nx;
    logic [ACC_BITS-1:0] spec_cnt, spec_nx, spec_inc;
    logic [ACC_BITS-1:0] acc_len_q, acc_len_nx;
    logic                pend, pend_nx, ovf_nx, drop;
    logic                win_done_nx, int_done_nx;

    assign spec_inc = spec_cnt + ACC_BITS'(1);

    always_comb begin
        state_nx    = state;
        bl_cnt_nx   = bl_cnt;
        spec_nx     = spec_cnt;
        acc_len_nx  = acc_len_q;
        pend_nx     = pend;
        ovf_nx      = overflow;
        drop        = 1'b0;
        win_done_nx = 1'b0;
        int_done_nx = 1'b0;
        if (sync) begin
            // A coincident win_req is the first window of the new integration.
            state_nx   = win_req ? SYNC : WAIT;
            acc_len_nx = (acc_len == '0) ? ACC_BITS'(1) : acc_len;
            spec_nx    = '0;
            pend_nx    = 1'b0;
            ovf_nx     = 1'b0;
        end else begin
            case (state)
                WAIT: if (win_req) state_nx = SYNC;
                SYNC: begin
                    state_nx  = RUN;
                    bl_cnt_nx = '0;
                    if (win_req) begin
                        if (pend) drop = 1'b1;
                        else      pend_nx = 1'b1;
                    end
                end
                RUN: begin
                    bl_cnt_nx = bl_cnt + BL_W'(1);
                    if (bl_cnt == BL_LAST) begin
                        win_done_nx = 1'b1;
                        if (spec_inc == acc_len_q) begin
                            spec_nx     = '0;
                            int_done_nx = 1'b1;
                        end else begin
                            spec_nx = spec_inc;
                        end
                        // The pending window is consumed here; a second request has nowhere to go.
                        drop     = pend & win_req;
                        state_nx = (pend | win_req) ? SYNC : WAIT;
                        pend_nx  = 1'b0;
                    end else if (win_req) begin
                        if (pend) drop = 1'b1;
                        else      pend_nx = 1'b1;
                    end
                end
                default: ;
            endcase
            if (drop) ovf_nx = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            bl_cnt    <= '0;
            spec_cnt  <= '0;
            acc_len_q <= ACC_BITS'(1);
            pend      <= 1'b0;
            overflow  <= 1'b0;
            bl_sync   <= 1'b0;
            bl_en     <= 1'b0;
            acc_first <= 1'b0;
            acc_last  <= 1'b0;
            win_done  <= 1'b0;
            int_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            bl_cnt    <= bl_cnt_nx;
            spec_cnt  <= spec_nx;
            acc_len_q <= acc_len_nx;
            pend      <= pend_nx;
            overflow  <= ovf_nx;
            // Outputs decode the next state so they line up with the state they describe.
            bl_sync   <= (state_nx == SYNC);
            bl_en     <= (state_nx == RUN);
            acc_first <= (state_nx == RUN) && (spec_nx == '0);
            acc_last  <= (state_nx == RUN) && (spec_nx == acc_len_nx - ACC_BITS'(1));
            win_done  <= win_done_nx;
            int_done  <= int_done_nx;
        end
    end

`ifdef XENG_BL_SCHED_STATUS_EN
    always_ff @(posedge clk) begin
        if (rst || sync) begin
            int_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (int_done_nx) int_cnt <= int_cnt + ACC_BITS'(1);
            if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_xeng_bl_sched.sv
// Directed bench for xeng_bl_sched at N_ANTS=4 (12-cycle passes).
module tb_xeng_bl_sched;
    localparam int ACC_BITS = 32;
    localparam int BL = 12;

    logic clk = 1'b0;
    logic rst, sync, win_req;
    logic [ACC_BITS-1:0] acc_len;
    logic bl_sync, bl_en, acc_first, acc_last, win_done, int_done, overflow;
`ifdef XENG_BL_SCHED_STATUS_EN
    logic [ACC_BITS-1:0] int_cnt;
    logic [15:0] drop_cnt;
`endif
    int n_chk = 0;
    int n_fail = 0;

    xeng_bl_sched #(.N_ANTS(4), .ACC_BITS(ACC_BITS)) dut (
        .clk(clk), .rst(rst), .sync(sync), .acc_len(acc_len), .win_req(win_req),
        .bl_sync(bl_sync), .bl_en(bl_en), .acc_first(acc_first), .acc_last(acc_last),
        .win_done(win_done), .int_done(int_done),
`ifdef XENG_BL_SCHED_STATUS_EN
        .int_cnt(int_cnt), .drop_cnt(drop_cnt),
`endif
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered in the SYNC cycle; exits in the cycle after the last bl_en.
    task automatic pass(input string tag, input logic ef, input logic el, input logic ei,
                        input int req_a, input int req_b, input logic nxt);
        chk({tag, ".sync"}, bl_sync, 1);
        chk({tag, ".en0"}, bl_en, 0);
        tick();
        for (int i = 0; i < BL; i++) begin
            chk($sformatf("%s.en[%0d]", tag, i), bl_en, 1);
            chk($sformatf("%s.first[%0d]", tag, i), acc_first, ef);
            chk($sformatf("%s.last[%0d]", tag, i), acc_last, el);
            chk($sformatf("%s.wd[%0d]", tag, i), win_done, 0);
            win_req = (i == req_a) || (i == req_b);
            tick();
            win_req = 1'b0;
        end
        chk({tag, ".win_done"}, win_done, 1);
        chk({tag, ".int_done"}, int_done, ei);
        chk({tag, ".en_off"}, bl_en, 0);
        chk({tag, ".next"}, bl_sync, nxt);
    endtask

    task automatic do_sync(input logic [ACC_BITS-1:0] len);
        sync = 1'b1; acc_len = len;
        tick();
        sync = 1'b0;
    endtask

    task automatic req();
        win_req = 1'b1;
        tick();
        win_req = 1'b0;
    endtask

    initial begin
        int cnt;
        rst = 1'b1; sync = 1'b0; win_req = 1'b0; acc_len = '0;
        tick(); tick();
        chk("rst.outs", {25'd0, bl_sync, bl_en, acc_first, acc_last, win_done, int_done, overflow}, 0);
        rst = 1'b0;
        tick();

        // IDLE ignores requests
        cnt = 0;
        req(); req();
        for (int i = 0; i < 6; i++) begin cnt += bl_sync + bl_en; tick(); end
        chk("idle.no_pass", cnt, 0);
        chk("idle.ovf", overflow, 0);

        // acc_len=3: three contiguous passes, fourth restarts the integration
        do_sync(3);
        tick();
        req();
        pass("p0", 1, 0, 0, 5, -1, 1);
        pass("p1", 0, 0, 0, 5, -1, 1);
        pass("p2", 0, 1, 1, 5, -1, 1);
        pass("p3", 1, 0, 0, -1, -1, 0);
        chk("p.ovf", overflow, 0);
`ifdef XENG_BL_SCHED_STATUS_EN
        chk("p.int_cnt", int_cnt, 1);
`endif

        // acc_len=0 behaves as 1
        do_sync(0);
        req();
        pass("z0", 1, 1, 1, 3, -1, 1);
        pass("z1", 1, 1, 1, -1, -1, 0);

        // two requests in one pass: second is dropped
        req();
        pass("o0", 1, 1, 1, 2, 7, 1);
        chk("o.ovf", overflow, 1);
`ifdef XENG_BL_SCHED_STATUS_EN
        chk("o.drop_cnt", drop_cnt, 1);
        chk("o.int_cnt", int_cnt, 3);
`endif
        pass("o1", 1, 1, 1, -1, -1, 0);
        chk("o.ovf_sticky", overflow, 1);

        // sync at bl_cnt=5 aborts the pass
        req();
        tick();
        for (int i = 0; i < 5; i++) tick();
        chk("ab.en_before", bl_en, 1);
        do_sync(3);
        chk("ab.en_off", bl_en, 0);
        chk("ab.ovf_clr", overflow, 0);
        cnt = 0;
        for (int i = 0; i < BL + 2; i++) begin cnt += win_done + bl_en + bl_sync; tick(); end
        chk("ab.no_done", cnt, 0);
`ifdef XENG_BL_SCHED_STATUS_EN
        chk("ab.drop_clr", drop_cnt, 0);
`endif
        req();
        pass("s0", 1, 0, 0, -1, -1, 0);

        // reset mid-RUN
        req();
        tick(); tick(); tick();
        chk("rr.en_before", bl_en, 1);
        rst = 1'b1;
        tick();
        chk("rr.outs", {25'd0, bl_sync, bl_en, acc_first, acc_last, win_done, int_done, overflow}, 0);
        rst = 1'b0;
        tick();
        cnt = 0;
        req();
        for (int i = 0; i < 4; i++) begin cnt += bl_sync + bl_en; tick(); end
        chk("rr.idle", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
